// File: rtl/gb_timer_pkg.sv
// Shared types and defaults for the GameBoy timer/divider block.
package gb_timer_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    PEND   = 2'd1,
    RELOAD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SEL_DIV  = 2'd0,
    SEL_TIMA = 2'd1,
    SEL_TMA  = 2'd2,
    SEL_TAC  = 2'd3
  } sel_t;

  localparam int DEF_TAP0 = 9;
  localparam int DEF_TAP1 = 3;
  localparam int DEF_TAP2 = 5;
  localparam int DEF_TAP3 = 7;

  function automatic int delayWidth(input int delay);
    return $clog2(delay) + 1;
  endfunction

endpackage

// File: rtl/gb_timer_if.sv
// Register write port from the memory unit plus timer status toward the core.
interface gb_timer_if #(parameter int CNT_W = 8) ();
  import gb_timer_pkg::*;

  logic             wr_en;
  sel_t             wr_sel;
  logic [CNT_W-1:0] wr_data;
  logic [7:0]       div_o;
  logic [CNT_W-1:0] tima_o;
  logic [CNT_W-1:0] tma_o;
  logic [2:0]       tac_o;
  logic             reload_pend_o;
  logic             irq;

  modport master (
    output wr_en, wr_sel, wr_data,
    input  div_o, tima_o, tma_o, tac_o, reload_pend_o, irq
  );

  modport slave (
    input  wr_en, wr_sel, wr_data,
    output div_o, tima_o, tma_o, tac_o, reload_pend_o, irq
  );

endinterface

// File: rtl/gb_timer_tick.sv
// TIMA tick source: selects a counter tap, gates it with the enable bit and
// fires on its falling edge, including glitch edges from DIV/TAC writes.
module gb_timer_tick (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_taps,
  input  logic [2:0] i_tac,
  output logic       o_tick
);

  logic w_tapBit;
  logic w_t;
  logic r_tPrev;

  assign w_tapBit = i_taps[i_tac[1:0]];
  assign w_t      = i_tac[2] & w_tapBit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tPrev <= 1'b0;
    end else begin
      r_tPrev <= w_t;
    end
  end

  assign o_tick = r_tPrev & ~w_t;

endmodule

// File: rtl/gb_timer.sv
// GameBoy DIV/TIMA/TMA/TAC timer with delayed overflow reload and a
// one-cycle interrupt request feeding interrupt_st[2].
module gb_timer import gb_timer_pkg::*; #(
  parameter int DIV_W        = 16,
  parameter int CNT_W        = 8,
  parameter int TAP0         = DEF_TAP0,
  parameter int TAP1         = DEF_TAP1,
  parameter int TAP2         = DEF_TAP2,
  parameter int TAP3         = DEF_TAP3,
  parameter int RELOAD_DELAY = 4
) (
  input logic        clk,
  input logic        rst,
  gb_timer_if.slave  bus
);

  localparam int               DLY_W    = delayWidth(RELOAD_DELAY);
  localparam logic [DLY_W-1:0] DLY_INIT = DLY_W'(RELOAD_DELAY - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [DIV_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_tima;
  logic [CNT_W-1:0] r_tma;
  logic [2:0]       r_tac;
  state_t           r_state;
  logic [DLY_W-1:0] r_dly;
  logic             r_pend;
  logic             r_irq;

  logic       w_tick;
  logic       w_wrDiv;
  logic       w_wrTima;
  logic       w_wrTma;
  logic       w_wrTac;
  logic [3:0] w_taps;

  assign w_wrDiv  = bus.wr_en && (bus.wr_sel == SEL_DIV);
  assign w_wrTima = bus.wr_en && (bus.wr_sel == SEL_TIMA);
  assign w_wrTma  = bus.wr_en && (bus.wr_sel == SEL_TMA);
  assign w_wrTac  = bus.wr_en && (bus.wr_sel == SEL_TAC);
  assign w_taps   = {r_cnt[TAP3], r_cnt[TAP2], r_cnt[TAP1], r_cnt[TAP0]};

  gb_timer_tick u_tick (
    .clk    (clk),
    .rst    (rst),
    .i_taps (w_taps),
    .i_tac  (r_tac),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_tma <= '0;
      r_tac <= '0;
    end else begin
      r_cnt <= w_wrDiv ? '0 : r_cnt + DIV_W'(1);
      if (w_wrTma) r_tma <= bus.wr_data;
      if (w_wrTac) r_tac <= bus.wr_data[2:0];
    end
  end

  // TIMA/TMA reload sequencer. TIMA already shows TMA and irq is high during
  // the RELOAD cycle, so the load happens on the last PEND cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_tima  <= '0;
      r_dly   <= '0;
      r_pend  <= 1'b0;
      r_irq   <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        RUN: begin
          if (w_wrTima) begin
            r_tima <= bus.wr_data;
          end else if (w_tick) begin
            if (r_tima == CNT_MAX) begin
              r_tima  <= '0;
              r_dly   <= DLY_INIT;
              r_pend  <= 1'b1;
              r_state <= PEND;
            end else begin
              r_tima <= r_tima + CNT_W'(1);
            end
          end
        end
        PEND: begin
          if (w_wrTima) begin
            r_tima  <= bus.wr_data;
            r_pend  <= 1'b0;
            r_state <= RUN;
          end else if (r_dly == '0) begin
            r_tima  <= r_tma;
            r_irq   <= 1'b1;
            r_pend  <= 1'b0;
            r_state <= RELOAD;
          end else begin
            r_dly <= r_dly - DLY_W'(1);
          end
        end
        RELOAD: begin
          r_tima  <= w_wrTma ? bus.wr_data : r_tma;
          r_state <= RUN;
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign bus.div_o         = r_cnt[DIV_W-1 -: 8];
  assign bus.tima_o        = r_tima;
  assign bus.tma_o         = r_tma;
  assign bus.tac_o         = r_tac;
  assign bus.reload_pend_o = r_pend;
  assign bus.irq           = r_irq;

endmodule

// File: tb/tb_gb_timer.sv
// Scoreboard bench for gb_timer: an 8-bit/16-bit build and a 4-bit/12-bit build
// run the same stimulus against a timeline-based reference model.
module tb_gb_timer;
  import gb_timer_pkg::*;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gb_timer_if #(.CNT_W(8)) bus0 ();
  gb_timer_if #(.CNT_W(4)) bus1 ();

  gb_timer #(.DIV_W(16), .CNT_W(8), .RELOAD_DELAY(RD)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  gb_timer #(.DIV_W(12), .CNT_W(4), .RELOAD_DELAY(RD)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    int div;
    int tima;
    int tma;
    int tac;
    int pend;
    int irq;
  } exp_t;

  exp_t   q0[$];
  exp_t   q1[$];
  int     nCompared   = 0;
  int     nMismatched = 0;
  bit     driverDone  = 1'b0;
  longint cyc         = 0;

  // Model state per build; mAt is the absolute cycle in which TIMA shows the
  // reloaded TMA value (-1 when no reload is scheduled).
  int     mCnt[2], mTima[2], mTma[2], mTac[2], mPrevT[2], mIrq[2], mPend[2];
  longint mAt[2];
  int     divW[2] = '{16, 12};
  int     cntW[2] = '{8, 4};

  function automatic int tapFor(input int s);
    case (s)
      0:       return 9;
      1:       return 3;
      2:       return 5;
      default: return 7;
    endcase
  endfunction

  task automatic modelStep(input int i, input bit r, input bit en, input int sel, input int dataIn);
    int     data, maxV, nTima, nIrq, t;
    bit     tick, wTima, wTma;
    longint nAt;
    maxV = (1 << cntW[i]) - 1;
    data = dataIn & maxV;
    if (r) begin
      mCnt[i] = 0; mTima[i] = 0; mTma[i] = 0; mTac[i] = 0;
      mPrevT[i] = 0; mIrq[i] = 0; mAt[i] = -1;
    end else begin
      t     = ((mTac[i] >> 2) & 1) & ((mCnt[i] >> tapFor(mTac[i] & 3)) & 1);
      tick  = (mPrevT[i] == 1) && (t == 0);
      wTima = en && (sel == 1);
      wTma  = en && (sel == 2);
      nTima = mTima[i];
      nIrq  = 0;
      nAt   = mAt[i];
      if (nAt >= 0 && cyc < nAt) begin
        if (wTima) begin
          nTima = data;
          nAt   = -1;
        end else if (cyc + 1 == nAt) begin
          nTima = mTma[i];
          nIrq  = 1;
        end else begin
          nTima = 0;
        end
      end else if (nAt >= 0 && cyc == nAt) begin
        nTima = wTma ? data : mTma[i];
        nAt   = -1;
      end else if (wTima) begin
        nTima = data;
      end else if (tick) begin
        if (mTima[i] == maxV) begin
          nTima = 0;
          nAt   = cyc + 1 + RD;
        end else begin
          nTima = mTima[i] + 1;
        end
      end
      mPrevT[i] = t;
      mCnt[i]   = (en && sel == 0) ? 0 : (mCnt[i] + 1) % (1 << divW[i]);
      if (wTma) mTma[i] = data;
      if (en && sel == 3) mTac[i] = data & 7;
      mTima[i] = nTima;
      mIrq[i]  = nIrq;
      mAt[i]   = nAt;
    end
    mPend[i] = (mAt[i] >= 0 && cyc + 1 < mAt[i]) ? 1 : 0;
  endtask

  task automatic applyStimulus(input bit r, input bit en, input int sel, input int data);
    exp_t e;
    @(negedge clk);
    rst          = r;
    bus0.wr_en   = en;
    bus0.wr_sel  = sel_t'(sel[1:0]);
    bus0.wr_data = 8'(data);
    bus1.wr_en   = en;
    bus1.wr_sel  = sel_t'(sel[1:0]);
    bus1.wr_data = 4'(data);
    for (int i = 0; i < 2; i++) begin
      modelStep(i, r, en, sel, data);
      e.div  = (mCnt[i] >> (divW[i] - 8)) & 255;
      e.tima = mTima[i];
      e.tma  = mTma[i];
      e.tac  = mTac[i];
      e.pend = mPend[i];
      e.irq  = mIrq[i];
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 0, 0);
  endtask

  task automatic wr(input int sel, input int data);
    applyStimulus(1'b0, 1'b1, sel, data);
  endtask

  task automatic setupOverflow();
    applyStimulus(1'b1, 1'b0, 0, 0);
    applyStimulus(1'b1, 1'b0, 0, 0);
    wr(3, 'h5);
    wr(2, 'h40);
    wr(1, 'hFE);
  endtask

  task automatic waitPend();
    for (int k = 0; k < 400 && mPend[0] == 0; k++) idle(1);
  endtask

  task automatic waitReload();
    for (int k = 0; k < 400 && mAt[0] != cyc; k++) idle(1);
  endtask

  task automatic waitBit3(input bit needBit9Low);
    for (int k = 0; k < 2048; k++) begin
      if (((mCnt[0] >> 3) & 1) == 1 && (!needBit9Low || ((mCnt[0] >> 9) & 1) == 0)) break;
      idle(1);
    end
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input int expv);
    nCompared++;
    if (act !== 32'(expv)) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, act, expv, $time);
    end
  endtask

  task automatic driver();
    int r, en, sel, data;
    // Overflow with delayed reload and irq
    setupOverflow();
    idle(90);
    // TIMA write during PEND cancels the reload
    setupOverflow();
    waitPend();
    idle(1);
    wr(1, 'h12);
    idle(20);
    // TMA write during RELOAD lands in TIMA
    setupOverflow();
    waitReload();
    wr(2, 'h77);
    idle(4);
    // TIMA write during RELOAD is ignored
    wr(1, 'hFF);
    waitReload();
    wr(1, 'h55);
    idle(4);
    // DIV write glitch ticks only when enabled
    applyStimulus(1'b1, 1'b0, 0, 0);
    wr(3, 'h5);
    wr(1, 'h10);
    waitBit3(1'b0);
    wr(0, 'hAB);
    idle(2);
    wr(3, 'h1);
    waitBit3(1'b0);
    wr(0, 'h00);
    idle(2);
    // TAC enable clear and select change glitches
    wr(3, 'h5);
    waitBit3(1'b0);
    wr(3, 'h1);
    idle(2);
    wr(3, 'h5);
    waitBit3(1'b1);
    wr(3, 'h4);
    idle(2);
    // Reset in the middle of PEND
    setupOverflow();
    waitPend();
    idle(1);
    applyStimulus(1'b1, 1'b0, 0, 0);
    idle(30);
    // Randomized traffic biased toward overflow
    for (int k = 0; k < 3000; k++) begin
      r    = ($urandom_range(0, 399) == 0) ? 1 : 0;
      en   = ($urandom_range(0, 5) == 0) ? 1 : 0;
      sel  = $urandom_range(0, 3);
      data = $urandom_range(0, 255);
      if (sel == 0 && $urandom_range(0, 3) != 0) en = 0;
      if (sel == 1 && $urandom_range(0, 1) == 1) data = 'hFC + $urandom_range(0, 3);
      if (sel == 3 && $urandom_range(0, 3) != 0) data = data | 4;
      applyStimulus(r[0], en[0], sel, data);
    end
    driverDone = 1'b1;
  endtask

  task automatic monitor();
    exp_t e0, e1;
    bit   ended;
    ended = 1'b0;
    for (int c = 0; c < 40000 && !ended; c++) begin
      @(posedge clk);
      #1;
      if (q0.size() > 0 && q1.size() > 0) begin
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        checkOutput("w8.div",  bus0.div_o,         e0.div);
        checkOutput("w8.tima", bus0.tima_o,        e0.tima);
        checkOutput("w8.tma",  bus0.tma_o,         e0.tma);
        checkOutput("w8.tac",  bus0.tac_o,         e0.tac);
        checkOutput("w8.pend", bus0.reload_pend_o, e0.pend);
        checkOutput("w8.irq",  bus0.irq,           e0.irq);
        checkOutput("w4.div",  bus1.div_o,         e1.div);
        checkOutput("w4.tima", bus1.tima_o,        e1.tima);
        checkOutput("w4.tma",  bus1.tma_o,         e1.tma);
        checkOutput("w4.tac",  bus1.tac_o,         e1.tac);
        checkOutput("w4.pend", bus1.reload_pend_o, e1.pend);
        checkOutput("w4.irq",  bus1.irq,           e1.irq);
      end else if (driverDone) begin
        ended = 1'b1;
      end
    end
    if (!ended) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL monitor_timeout: got %0d pending entries, expected 0", q0.size());
    end
  endtask

  initial begin
    bus0.wr_en = 1'b0; bus0.wr_sel = SEL_DIV; bus0.wr_data = '0;
    bus1.wr_en = 1'b0; bus1.wr_sel = SEL_DIV; bus1.wr_data = '0;
    for (int i = 0; i < 2; i++) begin
      mCnt[i] = 0; mTima[i] = 0; mTma[i] = 0; mTac[i] = 0;
      mPrevT[i] = 0; mIrq[i] = 0; mPend[i] = 0; mAt[i] = -1;
    end
    fork
      driver();
      monitor();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
